aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Control FSM for the iterative AES-128 encryption datapath: state register, shared sync-sbox subbytes/subword, shiftrows, mixcolumns, addroundkey and on-the-fly key expansion.
- Converts the SPI-side level `load` into a load/run/done sequence.
- Steps 10 rounds, each with a configurable sbox read latency.
- Drives datapath write enables, mux selects and the round constant, and raises `done` for the SPI block.

Parameters:
- SBOX_LAT, 1: cycles from sbox address to sbox data (0 = combinational LUT sbox, 1 = sbox_sync EBR); legal range 0..3.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  level from SPI master; high while key/plaintext are shifted in; falling edge starts encryption.
- load_en  out  1  datapath captures state <= plaintext ^ key and roundkey <= key.
- sb_issue  out  1  sbox addresses (state bytes and rotword of roundkey[31:0]) are valid this cycle.
- upd_en  out  1  datapath writes state <= ARK(MC?(SR(SB(state)))) and roundkey <= next roundkey.
- mc_en  out  1  mixcolumns applied on this update.
- rcon  out  8  round constant byte for the current key-expansion step.
- round  out  4  current round number, 0..10.
- ct_we  out  1  one-cycle pulse; cyphertext valid in the state register on the next cycle.
- done  out  1  encryption complete; held until next load.

Behaviour:
- Async reset (immediate, independent of clk): FSM=IDLE, round=0, phase=0, rcon=8'h00.
  - All outputs 0 while reset is high and after release until load is seen.
- Outputs are combinational decodes of registered FSM/round/phase/rcon only. No combinational path from load to outputs.
- States:
  - IDLE: all outputs 0. load=1 -> LOAD.
  - LOAD: load_en=1 every cycle; round=0.
    - load=0 sampled -> RUN, with round<=1, phase<=0, rcon<=8'h01.
  - RUN: phase counts 0..SBOX_LAT, then wraps to 0.
    - sb_issue=1 when phase==0.
    - upd_en=1 when phase==SBOX_LAT. With SBOX_LAT=0, sb_issue and upd_en are both high every RUN cycle.
    - mc_en = upd_en & (round!=10).
    - On upd_en with round<10: round<=round+1 and rcon<=xtime(rcon), where xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00).
    - On upd_en with round==10: ct_we=1 that cycle, then -> DONE.
  - DONE: done=1; round holds 10; rcon holds 8'h36; load_en/upd_en/sb_issue=0.
    - load=1 sampled -> LOAD; done falls the next cycle.
- rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36. rcon=8'h00 in IDLE and LOAD.
- Latency: the first RUN cycle is the edge after load is sampled low. ct_we occurs in RUN cycle 10*(SBOX_LAT+1), counting from 1. done rises on the following cycle.
  - SBOX_LAT=1: ct_we on cycle 20, done on cycle 21.
- Abort: load=1 sampled in RUN (any phase, any round) -> LOAD next cycle.
  - round<=0, phase<=0, rcon<=8'h00; no ct_we and no done.
  - The upd_en of that cycle still occurs as decoded, and the datapath result is discarded by the LOAD reload.
- load glitch: 1-cycle load pulse from IDLE/DONE -> LOAD one cycle, then RUN. Legal; encrypts whatever was shifted.
- Reset asserted mid-RUN or in DONE -> IDLE immediately; done and ct_we drop asynchronously.
- upd_en and load_en are never high in the same cycle. ct_we is high only together with upd_en & round==10.
- Counters never wrap beyond range: round in 0..10, phase in 0..SBOX_LAT. Unreachable encodings go to IDLE.

Test Plan:
- Reset: assert reset mid-cycle with load=1 -> all outputs 0 asynchronously. Release with load=0 -> stays IDLE, round=0, rcon=00.
- Nominal, SBOX_LAT=1: load high 256 cycles then low.
  - load_en=1 throughout the load phase.
  - upd_en on RUN cycles 2,4,...,20.
  - rcon at those cycles = 01,02,04,08,10,20,40,80,1b,36.
  - mc_en=1 on the first 9 updates, 0 on the 10th.
  - ct_we on cycle 20; done=1 from cycle 21 until load returns.
  - With the FIPS-197 App. B vectors the datapath yields 3925841d02dc09fbdc118597196a0b32.
- SBOX_LAT=0: same stimulus -> upd_en and sb_issue high on RUN cycles 1..10, ct_we on cycle 10, done on cycle 11.
- Abort: raise load in round 5, phase 0 -> LOAD next cycle, round=0, rcon=00. No ct_we/done. Lower load -> full 20-cycle run completes normally.
- Back-to-back: in DONE, raise load for 1 cycle -> done falls after 1 cycle, one LOAD cycle, then RUN from round 1 with rcon=01.
- Async reset in round 7 -> outputs 0 before the next clk edge. Subsequent load restarts cleanly.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Control FSM for an iterative AES-128 encryption datapath. It turns the
// SPI-side `load` level into a load / run / done sequence. During run it steps
// rounds 1..10. Each round issues the sbox addresses, waits SBOX_LAT cycles for
// the sbox data, and then commits one round update. The round constant for
// on-the-fly key expansion is generated here as well.
//
// Parameters
//   SBOX_LAT  cycles from sbox address to sbox data (0..3)
//
// Ports
//   clk       system clock, all state on posedge
//   reset     asynchronous, active-high reset
//   load      SPI load level; its falling edge starts encryption
//   load_en   datapath captures state <= pt ^ key, roundkey <= key
//   sb_issue  sbox addresses valid this cycle
//   upd_en    datapath commits one round (SB, SR, MC?, ARK, next key)
//   mc_en     mixcolumns applied on this update (not in the last round)
//   rcon      round constant for the current key-expansion step
//   round     current round number 0..10
//   ct_we     one-cycle pulse, ciphertext in state register next cycle
//   done      encryption complete, held until the next load
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int SBOX_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    output logic       load_en,
    output logic       sb_issue,
    output logic       upd_en,
    output logic       mc_en,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       ct_we,
    output logic       done
);

    localparam logic [1:0] LAT        = 2'(SBOX_LAT);
    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] rcon_q,  rcon_d;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            phase_q <= 2'd0;
            rcon_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            phase_q <= phase_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        phase_d = phase_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = LOAD;
                    round_d = 4'd0;
                    phase_d = 2'd0;
                    rcon_d  = 8'h00;
                end
            end
            LOAD: begin
                round_d = 4'd0;
                phase_d = 2'd0;
                rcon_d  = 8'h00;
                if (!load) begin
                    state_d = RUN;
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                end
            end
            RUN: begin
                if (round_q == 4'd0 || round_q > LAST_ROUND || phase_q > LAT) begin
                    // Counter encodings outside the legal run range.
                    state_d = IDLE;
                    round_d = 4'd0;
                    phase_d = 2'd0;
                    rcon_d  = 8'h00;
                end else if (load) begin
                    // Abort: the reload in LOAD overwrites whatever the
                    // datapath committed this cycle.
                    state_d = LOAD;
                    round_d = 4'd0;
                    phase_d = 2'd0;
                    rcon_d  = 8'h00;
                end else if (phase_q == LAT) begin
                    phase_d = 2'd0;
                    if (round_q == LAST_ROUND) begin
                        // round and rcon stay at 10 / 36 through DONE.
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            DONE: begin
                if (load) begin
                    state_d = LOAD;
                    round_d = 4'd0;
                    phase_d = 2'd0;
                    rcon_d  = 8'h00;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = 4'd0;
                phase_d = 2'd0;
                rcon_d  = 8'h00;
            end
        endcase
    end

    // Outputs decode registered state only; load never reaches them directly.
    logic in_run;
    assign in_run   = (state_q == RUN);
    assign load_en  = (state_q == LOAD);
    assign done     = (state_q == DONE);
    assign sb_issue = in_run && (phase_q == 2'd0);
    assign upd_en   = in_run && (phase_q == LAT);
    assign mc_en    = upd_en && (round_q != LAST_ROUND);
    assign ct_we    = upd_en && (round_q == LAST_ROUND);
    assign round    = round_q;
    assign rcon     = rcon_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Two sequencers (SBOX_LAT=1 as dut index 0, SBOX_LAT=0 as dut index 1) share
// clk/reset/load. When load falls, the expected update and sbox-issue events of
// the coming run are computed from the timing rules and pushed into a
// scoreboard queue. A negedge monitor pops and compares them whenever a DUT
// raises upd_en / sb_issue. Raising load flushes events that lie beyond the
// abort point.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    localparam int INF = 32'h7fffffff;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic load  = 1'b0;

    logic       load_en_v  [2];
    logic       sb_issue_v [2];
    logic       upd_en_v   [2];
    logic       mc_en_v    [2];
    logic [7:0] rcon_v     [2];
    logic [3:0] round_v    [2];
    logic       ct_we_v    [2];
    logic       done_v     [2];

    always #5 clk = ~clk;

    aes_round_sequencer #(.SBOX_LAT(1)) dut_lat1 (
        .clk(clk), .reset(reset), .load(load),
        .load_en(load_en_v[0]), .sb_issue(sb_issue_v[0]), .upd_en(upd_en_v[0]),
        .mc_en(mc_en_v[0]), .rcon(rcon_v[0]), .round(round_v[0]),
        .ct_we(ct_we_v[0]), .done(done_v[0])
    );

    aes_round_sequencer #(.SBOX_LAT(0)) dut_lat0 (
        .clk(clk), .reset(reset), .load(load),
        .load_en(load_en_v[1]), .sb_issue(sb_issue_v[1]), .upd_en(upd_en_v[1]),
        .mc_en(mc_en_v[1]), .rcon(rcon_v[1]), .round(round_v[1]),
        .ct_we(ct_we_v[1]), .done(done_v[1])
    );

    typedef struct {
        int dut;
        int kind;   // 0 = round update, 1 = sbox issue
        int stamp;  // cycle number in which the event must appear
        int rnd;
        int rc;
        int mc;
        int ct;
    } ev_t;

    ev_t  ev_q[$];
    int   cyc = 0;
    logic load_prev = 1'b0;   // load as sampled at the last edge
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_from  [2] = '{INF, INF};
    int   done_until [2] = '{INF, INF};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) load_prev <= 1'b0;
        else       load_prev <= load;
    end

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected events of a run whose load=0 is sampled at the next edge.
    task automatic lower_load();
        int c;
        int rc;
        load = 1'b0;
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            rc = 1;
            for (int k = 1; k <= 10; k++) begin
                if (k > 1) begin
                    rc = rc * 2;
                    if (rc > 255) rc = rc ^ 'h11b;
                end
                ev_q.push_back('{d, 0, c + k * (lat(d) + 1), k, rc, (k != 10), (k == 10)});
                ev_q.push_back('{d, 1, c + (k - 1) * (lat(d) + 1) + 1, k, rc, 0, 0});
            end
            done_from[d]  = c + 10 * (lat(d) + 1) + 1;
            done_until[d] = INF;
        end
        $display("run start: load low sampled at cycle %0d", c + 1);
    endtask

    task automatic raise_load();
        load = 1'b1;
        for (int i = ev_q.size() - 1; i >= 0; i--)
            if (ev_q[i].stamp >= cyc + 1) ev_q.delete(i);
        for (int d = 0; d < 2; d++)
            if (done_until[d] > cyc + 1) done_until[d] = cyc + 1;
    endtask

    task automatic model_reset();
        ev_q.delete();
        for (int d = 0; d < 2; d++) begin
            done_from[d]  = INF;
            done_until[d] = INF;
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_load_en"},  d, load_en_v[d],  0);
            chk({tag, "_sb_issue"}, d, sb_issue_v[d], 0);
            chk({tag, "_upd_en"},   d, upd_en_v[d],   0);
            chk({tag, "_mc_en"},    d, mc_en_v[d],    0);
            chk({tag, "_rcon"},     d, rcon_v[d],     0);
            chk({tag, "_round"},    d, round_v[d],    0);
            chk({tag, "_ct_we"},    d, ct_we_v[d],    0);
            chk({tag, "_done"},     d, done_v[d],     0);
        end
    endtask

    function automatic int find_ev(input int d, input int kind);
        for (int i = 0; i < ev_q.size(); i++)
            if (ev_q[i].dut == d && ev_q[i].kind == kind) return i;
        return -1;
    endfunction

    task automatic mon(input int d);
        int  i;
        logic exp_done;
        i = find_ev(d, 0);
        if (upd_en_v[d]) begin
            if (i < 0) begin
                chk("upd_unexpected", d, 1, 0);
            end else begin
                chk("upd_cycle", d, cyc, ev_q[i].stamp);
                chk("upd_round", d, round_v[d], ev_q[i].rnd);
                chk("upd_rcon",  d, rcon_v[d],  ev_q[i].rc);
                chk("upd_mc_en", d, mc_en_v[d], ev_q[i].mc);
                chk("upd_ct_we", d, ct_we_v[d], ev_q[i].ct);
                $display("update dut%0d cycle %0d round %0d rcon %02h mc %0d ct %0d",
                         d, cyc, round_v[d], rcon_v[d], mc_en_v[d], ct_we_v[d]);
                ev_q.delete(i);
            end
        end else if (i >= 0 && ev_q[i].stamp <= cyc) begin
            chk("upd_missed", d, 0, 1);
            ev_q.delete(i);
        end
        i = find_ev(d, 1);
        if (sb_issue_v[d]) begin
            if (i < 0) begin
                chk("sb_unexpected", d, 1, 0);
            end else begin
                chk("sb_cycle", d, cyc, ev_q[i].stamp);
                chk("sb_round", d, round_v[d], ev_q[i].rnd);
                ev_q.delete(i);
            end
        end else if (i >= 0 && ev_q[i].stamp <= cyc) begin
            chk("sb_missed", d, 0, 1);
            ev_q.delete(i);
        end
        chk("load_en", d, load_en_v[d], load_prev);
        chk("no_overlap", d, load_en_v[d] & upd_en_v[d], 0);
        exp_done = (cyc >= done_from[d]) && (cyc < done_until[d]);
        chk("done", d, done_v[d], exp_done);
        if (load_prev) begin
            chk("load_round", d, round_v[d], 0);
            chk("load_rcon",  d, rcon_v[d],  0);
        end
        if (exp_done) begin
            chk("done_round", d, round_v[d], 10);
            chk("done_rcon",  d, rcon_v[d],  'h36);
        end
        if (!upd_en_v[d]) begin
            chk("ct_we_idle", d, ct_we_v[d], 0);
            chk("mc_en_idle", d, mc_en_v[d], 0);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        // Reset held from time 0; outputs must be idle.
        #12;
        chk_zero("por");
        tick(1);
        #3 reset = 1'b0;
        tick(2);

        // Reset asserted mid-cycle while in LOAD with load high.
        raise_load();
        tick(3);
        #3 reset = 1'b1;
        #1 chk_zero("async_rst_load");
        model_reset();
        load = 1'b0;
        tick(1);
        #3 reset = 1'b0;
        tick(3);
        chk_zero("post_rst_idle");

        // Nominal long load, then full run.
        raise_load();
        tick(256);
        lower_load();
        tick(30);

        // Back-to-back one-cycle load pulse from DONE.
        raise_load();
        tick(1);
        lower_load();
        tick(30);

        // Abort in round 5, phase 0 of the SBOX_LAT=1 sequencer.
        raise_load();
        tick(10);
        lower_load();
        tick(9);
        chk("abort_point_round", 0, round_v[0], 5);
        chk("abort_point_sb", 0, sb_issue_v[0], 1);
        raise_load();
        tick(1);
        chk("abort_round", 0, round_v[0], 0);
        chk("abort_rcon",  0, rcon_v[0],  0);
        tick(4);
        lower_load();
        tick(30);

        // Random load pulses and random abort points.
        repeat (10) begin
            raise_load();
            tick($urandom_range(1, 4));
            lower_load();
            tick($urandom_range(1, 26));
        end
        tick(30);

        // Async reset in round 7 of the SBOX_LAT=1 run, then clean restart.
        raise_load();
        tick(3);
        lower_load();
        tick(13);
        chk("rst_point_round", 0, round_v[0], 7);
        #3 reset = 1'b1;
        #1 chk_zero("async_rst_run");
        model_reset();
        tick(1);
        #3 reset = 1'b0;
        tick(2);
        raise_load();
        tick(3);
        lower_load();
        tick(30);

        foreach (ev_q[i]) chk("leftover_event", ev_q[i].dut, ev_q[i].stamp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
